// File: rtl/seq_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ser_pkg
//  Purpose  : Shared types and default parameter values for the
//             parallel-to-serial front end (seq_serializer).
//  Contents : ser_state_t     - shifter state encoding
//             SER_*_DEF       - default WIDTH / bit order / idle level
//  Revision : 1.0 - initial release
// ============================================================================
package seq_ser_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int unsigned SER_WIDTH_DEF     = 8;
  localparam bit          SER_MSB_FIRST_DEF = 1'b1;
  localparam bit          SER_IDLE_BIT_DEF  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seq_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_serializer_if
//  Purpose  : Word-in / bit-out bundle of the serializer.
//  Ports    : din, din_valid   - parallel word + qualifier (producer -> DUT)
//             din_ready        - holding register can take a word
//             sout, bit_valid  - serial bit stream + qualifier
//             last             - final bit of the current word
//             busy             - word shifting or queued
//  Modports : master = producer/consumer side, slave = serializer
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_serializer_if
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             bit_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, bit_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, bit_valid, last, busy
  );

endinterface
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_serializer
//  Purpose  : Parallel-to-serial converter feeding a bit-serial sequence
//             detector. A one-word holding register lets the next word queue
//             while the current one shifts, giving a gap-free bit stream.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous, active-high
//             bus    - seq_serializer_if.slave (din/din_valid/din_ready,
//                      sout/bit_valid/last/busy)
//  Params   : WIDTH (>= 2), MSB_FIRST (1: din[WIDTH-1] first), IDLE_BIT
//  Revision : 1.0 - initial release
// ============================================================================
module seq_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter bit MSB_FIRST = SER_MSB_FIRST_DEF,
  parameter bit IDLE_BIT  = SER_IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  seq_serializer_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] sh_d;      // shift register after one step toward the output end
  logic             sh_out;    // bit currently at the output end
  logic             accept;
  logic             shifting;

  // Output end and shift direction depend only on the bit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_d   = {sh_q[WIDTH-2:0], 1'b0};
      assign sh_out = sh_q[WIDTH-1];
    end else begin : g_lsb_first
      assign sh_d   = {1'b0, sh_q[WIDTH-1:1]};
      assign sh_out = sh_q[0];
    end
  endgenerate

  // Ready is held low during reset so nothing is captured on the reset edge.
  assign bus.din_ready = !hold_full_q && !reset;
  assign accept        = bus.din_valid && bus.din_ready;

  // Accept (needs hold empty) and drain (needs hold full) are mutually
  // exclusive, so the two hold_full_q writes below never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SER_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        hold_q      <= bus.din;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        SER_IDLE: begin
          if (hold_full_q) begin
            sh_q        <= hold_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            state_q     <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
          end else if (hold_full_q) begin
            // Seamless reload: first bit of the next word follows immediately.
            sh_q        <= hold_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
          end else begin
            cnt_q   <= '0;
            state_q <= SER_IDLE;
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  // All outputs decode registers only.
  assign shifting      = (state_q == SER_SHIFT);
  assign bus.bit_valid = shifting;
  assign bus.sout      = shifting ? sh_out : IDLE_BIT;
  assign bus.last      = shifting && (cnt_q == CNT_LAST);
  assign bus.busy      = shifting || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_serializer
//  Purpose  : Self-checking bench for seq_serializer. Two instances:
//             dut0 = MSB first, idle level 1; dut1 = LSB first, idle level 0.
//             Accepted words are expanded into expected bits on a per-DUT
//             queue and popped whenever the DUT flags a valid bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;
  import seq_ser_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_serializer_if #(.WIDTH(W)) bus0 ();
  seq_serializer_if #(.WIDTH(W)) bus1 ();

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  exp_t q [2][$];
  int   valid_cnt [2];
  int   run       [2];
  int   last_run  [2];
  int   n_acc     [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input int id, input logic [W-1:0] w, input bit msb);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = msb ? w[W-1-i] : w[i];
      e.l = (i == W - 1);
      q[id].push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic sout, input logic bv, input logic lst,
                     input logic busy, input logic idle_lvl);
    exp_t e;
    if (bv) begin
      valid_cnt[id]++;
      run[id]++;
      if (q[id].size() == 0) begin
        check($sformatf("d%0d_unexpected_bit", id), 32'd1, 32'd0);
      end else begin
        e = q[id].pop_front();
        check($sformatf("d%0d_sout", id), {31'd0, sout}, {31'd0, e.b});
        check($sformatf("d%0d_last", id), {31'd0, lst}, {31'd0, e.l});
      end
      check($sformatf("d%0d_busy_shift", id), {31'd0, busy}, 32'd1);
    end else begin
      if (run[id] != 0) begin
        last_run[id] = run[id];
        run[id]      = 0;
      end
      check($sformatf("d%0d_idle_sout", id), {31'd0, sout}, {31'd0, idle_lvl});
      check($sformatf("d%0d_idle_last", id), {31'd0, lst}, 32'd0);
      check($sformatf("d%0d_idle_busy", id), {31'd0, busy}, {31'd0, (q[id].size() != 0)});
    end
  endtask

  // Inputs only change just after a rising edge, so values seen here are the
  // ones the DUT samples on the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus0.sout, bus0.bit_valid, bus0.last, bus0.busy, 1'b1);
      mon(1, bus1.sout, bus1.bit_valid, bus1.last, bus1.busy, 1'b0);
      if (bus0.din_valid && bus0.din_ready) begin
        push_word(0, bus0.din, 1'b1);
        n_acc[0]++;
      end
      if (bus1.din_valid && bus1.din_ready) begin
        push_word(1, bus1.din, 1'b0);
        n_acc[1]++;
      end
      if (reset) begin
        // Reset takes effect at the coming edge: in-flight words are discarded.
        q[0].delete();
        q[1].delete();
        run[0] = 0;
        run[1] = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a word and returns just after the accepting edge; din_valid is
  // left high so calls can be chained without a bubble.
  task automatic send(input int id, input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    if (id == 0) begin bus0.din = w; bus0.din_valid = 1'b1; end
    else         begin bus1.din = w; bus1.din_valid = 1'b1; end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus0.din_ready : bus1.din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("d%0d_send_timeout", id), 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int id);
    if (id == 0) bus0.din_valid = 1'b0;
    else         bus1.din_valid = 1'b0;
  endtask

  initial begin
    int base;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      valid_cnt[i] = 0; run[i] = 0; last_run[i] = 0; n_acc[i] = 0;
    end
    bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0;

    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_ready0", {31'd0, bus0.din_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus1.din_ready}, 32'd0);
    check("rst_bv0",    {31'd0, bus0.bit_valid}, 32'd0);
    check("rst_busy0",  {31'd0, bus0.busy},      32'd0);
    check("rst_sout0",  {31'd0, bus0.sout},      32'd1);
    check("rst_sout1",  {31'd0, bus1.sout},      32'd0);
    check("rst_last0",  {31'd0, bus0.last},      32'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rel_ready0", {31'd0, bus0.din_ready}, 32'd1);
    check("rel_ready1", {31'd0, bus1.din_ready}, 32'd1);
    cycles(1);

    // Single word, MSB first, with first-bit latency
    send(0, 8'h36);
    drop(0);
    @(negedge clk);
    check("single_ready_low", {31'd0, bus0.din_ready}, 32'd0);
    check("single_bv_wait",   {31'd0, bus0.bit_valid}, 32'd0);
    @(negedge clk);
    check("single_bv_first",  {31'd0, bus0.bit_valid}, 32'd1);
    cycles(12);
    check("single_run", last_run[0], 32'd8);

    // LSB first on dut1
    send(1, 8'h36);
    drop(1);
    cycles(14);
    check("lsb_run", last_run[1], 32'd8);

    // Back-to-back words: one contiguous 16-bit burst
    send(0, 8'h36);
    send(0, 8'hA5);
    drop(0);
    cycles(24);
    check("b2b_run", last_run[0], 32'd16);

    // Backpressure: valid held high across three words
    base = n_acc[0];
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    drop(0);
    cycles(40);
    check("bp_accepts", n_acc[0] - base, 32'd3);
    check("bp_run",     last_run[0],     32'd24);

    // Reset mid-word with a word queued
    base = valid_cnt[0];
    send(0, 8'hFF);
    send(0, 8'h00);
    drop(0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_cnt[0] - base >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("midrst_wait_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_sout",  {31'd0, bus0.sout},      32'd1);
    check("midrst_bv",    {31'd0, bus0.bit_valid}, 32'd0);
    check("midrst_busy",  {31'd0, bus0.busy},      32'd0);
    check("midrst_ready", {31'd0, bus0.din_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    base  = valid_cnt[0];
    @(negedge clk);
    check("midrst_rel_ready", {31'd0, bus0.din_ready}, 32'd1);

    // Idle level on dut1, and nothing leaks out of dut0 after the reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle1_sout",  {31'd0, bus1.sout},      32'd0);
      check("idle1_bv",    {31'd0, bus1.bit_valid}, 32'd0);
      check("idle1_ready", {31'd0, bus1.din_ready}, 32'd1);
    end
    check("midrst_no_bits", valid_cnt[0] - base, 32'd0);

    check("end_q0_empty", q[0].size(), 32'd0);
    check("end_q1_empty", q[1].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the bit-serial sequence detectors. It accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock on `sout`, which drives the detector's `in` port directly. A one-word holding register lets the next word be queued while the current word shifts, so consecutive words produce a gap-free bit stream. Between words, `sout` holds a fixed idle level.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
- `IDLE_BIT`, default 1: `sout` level when no word is shifting.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in WIDTH: parallel word.
- `din_valid` in 1: `din` is valid this cycle.
- `din_ready` out 1: the holding register can accept a word.
- `sout` out 1: serial bit, fed to the detector `in`.
- `bit_valid` out 1: `sout` carries a data bit this cycle.
- `last` out 1: `sout` is the final bit of the current word.
- `busy` out 1: a word is shifting or a word is queued.

## Operation
- **Storage:** holding register `hold` with flag `hold_full`; shift register `sh` (WIDTH bits); bit counter `cnt` of width $clog2(WIDTH).
- **Handshake:**
  - Transfer occurs when `din_valid && din_ready` at a rising edge.
  - `din_ready = !hold_full && !reset`.
  - `din` is ignored when `din_ready` is low.
- **State machine:** states SER_IDLE and SER_SHIFT.
  - SER_IDLE with `hold_full`: load `sh` from `hold`, set `cnt=0`, clear `hold_full`, go to SER_SHIFT.
  - SER_SHIFT with `cnt < WIDTH-1`: shift `sh` toward the output end and increment `cnt`.
  - SER_SHIFT with `cnt == WIDTH-1` and `hold_full`: reload `sh` from `hold`, set `cnt=0`, clear `hold_full`, stay in SER_SHIFT (seamless).
  - SER_SHIFT with `cnt == WIDTH-1` and `!hold_full`: go to SER_IDLE.
- **Outputs:**
  - `sout` is the output-end bit of `sh` in SER_SHIFT, and IDLE_BIT in SER_IDLE.
  - `bit_valid = (state == SER_SHIFT)`.
  - `last = bit_valid && cnt == WIDTH-1`.
  - `busy = bit_valid || hold_full`.
- **Simultaneous accept and drain:** a transfer into `hold` and a load out of `hold` can never coincide, because `din_ready` is low whenever `hold_full` is set.
- **Reset (including mid-word):**
  - Discards `hold` and `sh`; no partial word is completed.
  - After the reset edge: SER_IDLE, `cnt=0`, `hold_full=0`, `sout=IDLE_BIT`, `bit_valid=0`, `last=0`, `busy=0`.
  - `din_ready` is 0 while `reset` is high and 1 in the first cycle after it deasserts.

## Timing
- **Latency:** a word accepted at edge k is in `hold` after k. At edge k+1 it loads into `sh` if the shifter is idle. Its first bit appears on `sout` in the cycle after edge k+1.
- **Throughput:** one word per WIDTH cycles, sustained while the producer keeps `hold` filled.
- **Back-to-back words:** bit 0 of word B follows bit WIDTH-1 of word A with no gap. `bit_valid` stays high continuously.
- **Re-queue window:** after `hold` drains into `sh`, `din_ready` rises in the next cycle. The producer has WIDTH-1 cycles to refill `hold` without a gap appearing.
- **Glitch-free outputs:** all outputs are functions of registers only.

## Structure
- **Package `seq_ser_pkg`:**
  - enum `ser_state_t` {SER_IDLE, SER_SHIFT};
  - default parameter constants for WIDTH and IDLE_BIT.
- **Single module, no sub-modules.** The hold and shift registers are small enough to stay inline.

## Test plan
- **Single word:** WIDTH=8, MSB_FIRST=1, accept 8'h36 at edge k → `sout` = 0,0,1,1,0,1,1,0 in cycles k+2…k+9 with `bit_valid` high. `last` is high only in k+9. `sout` is 1 from k+10. A downstream 0110 detector pulses exactly once.
- **Back-to-back:** words 8'h36 then 8'hA5, with the second presented while the first shifts → 16 contiguous `bit_valid` cycles with no idle bit between the words. `din_ready` goes low on accept and returns high one cycle after each reload.
- **Backpressure:** hold `din_valid` high with three words while the first shifts and `hold` is full → `din_ready` stays 0 until reload. No word is dropped or duplicated, and output order is preserved.
- **LSB-first:** MSB_FIRST=0, word 8'h36 → `sout` = 0,1,1,0,1,1,0,0.
- **Reset mid-word:** assert `reset` after bit 3 of 8'hFF with 8'h00 queued → next cycle `sout`=1 (IDLE_BIT), `bit_valid`=0, `busy`=0. After release, nothing is emitted until a new word is accepted.
- **Idle level:** IDLE_BIT=0 and no input for 20 cycles → `sout`=0, `bit_valid`=0, `din_ready`=1 throughout.
